ym3438_slot_timer: RTL and testbench
====================================

Name: ym3438_slot_timer

Overview:
- Downstream consumer of the prescaler's internal two-phase clocks (c1, c2) and its reset_fsm pulse.
- Generates the 24-slot operator/channel timebase used by all FM pipeline stages: slot counter, channel/operator indices, frame boundary flags and sample strobe.
- All logic is MCLK-synchronous; c1/c2 are treated as MCLK-domain levels and edge-detected.

Parameters:
- SLOTS, 24, slots per sample frame (must be a multiple of OPS).
- OPS, 4, operators per channel; channels = SLOTS/OPS.
- PERIOD, 6, expected MCLK cycles between c2 rising edges (watchdog only).

Ports:
- MCLK  in  1  master clock.
- IC  in  1  reset: synchronous, active-low.
- c1  in  1  internal phase-1 clock level from the prescaler.
- c2  in  1  internal phase-2 clock level from the prescaler.
- reset_fsm  in  1  timebase resync pulse from the prescaler.
- slot  out  clog2(SLOTS)  current slot, registered.
- ch  out  clog2(SLOTS/OPS)  slot % (SLOTS/OPS).
- op  out  clog2(OPS)  slot / (SLOTS/OPS).
- slot_first  out  1  latched slot == 0.
- slot_last  out  1  latched slot == SLOTS-1.
- sample_stb  out  1  one-MCLK frame-complete pulse.
- synced  out  1  timebase has seen reset_fsm since IC.
- period_err  out  1  sticky c2 period fault (present only with the optional feature).

Behaviour:
- Registers c1_d and c2_d hold the previous MCLK sample. c1_rise = c1 & ~c1_d; c2_rise = c2 & ~c2_d.
- IC low at a clock edge forces all state and outputs to 0: slot_cnt, c1_d, c2_d, slot, ch, op, slot_first, slot_last, sample_stb, synced, period_err.
- Internal slot_cnt priority, evaluated per MCLK edge:
  - reset_fsm = 1 -> 0; also sets synced = 1. Reset wins over a coincident c2_rise.
  - else if c2_rise: slot_cnt == SLOTS-1 -> 0, otherwise +1.
  - else hold.
- Output latch: on c1_rise, slot/ch/op/slot_first/slot_last are loaded from slot_cnt in the same edge. Outputs therefore change only on c1 rises, lagging the c2 advance by exactly one c1 edge (nominally 3 MCLK with the 6-cycle prescaler pattern).
- sample_stb:
  - High for exactly one MCLK, on the edge where c1_rise loads slot = 0 while the previous latched slot was SLOTS-1 and synced = 1.
  - Never asserted on a load caused by reset_fsm; a forced 0 does not count as a wrap.
- Coincident c1_rise and c2_rise (not produced by a healthy prescaler): the latch takes the pre-increment slot_cnt.
- reset_fsm mid-frame (e.g. slot_cnt = 13): slot_cnt -> 0 at that edge. Outputs follow at the next c1_rise with no sample_stb.
- Before synced, the counter still runs freely from 0; downstream gates on synced.
- Widths: ch/op computed with constant division/modulo on slot_cnt; no runtime divider.

Optional Feature:
- Macro: YM3438_SLOT_PERIOD_CHECK_EN.
- With the macro defined:
  - A 4-bit saturating counter counts MCLK edges since the last c2_rise. It restarts at 1 on each c2_rise.
  - At each c2_rise where synced = 1 and a previous c2_rise has been seen since the last reset_fsm, a count != PERIOD sets period_err = 1.
  - period_err is sticky; it is cleared only by IC low. reset_fsm discards the pending interval.
- Without the macro: the period_err port and all watchdog logic are absent.

Decomposition:
- Shared package ym3438_timing_pkg holds:
  - constants YM_SLOTS = 24, YM_OPS = 4, YM_CHANNELS = 6, YM_PRESCALE = 6;
  - slot/ch/op width typedefs.
- One sub-module, ym3438_edge_det (registered level + rise pulse), instantiated for c1 and c2.

Test Plan:
- IC low 3 cycles with c1/c2 toggling -> all outputs 0, synced 0. After IC high, outputs hold until the first c1_rise.
- Prescaler pattern (c1 at phases 0,5; c2 at 2,3; period 6), reset_fsm pulse, then 24 c2 rises:
  - slot steps 0..23 then wraps to 0;
  - sample_stb is exactly one MCLK wide at the wrap;
  - slot_first at slot 0 and slot_last at slot 23.
- Advance to slot 7 -> ch = 1, op = 1. Slot 23 -> ch = 5, op = 3.
- reset_fsm asserted when slot_cnt = 13 -> next c1_rise gives slot = 0, sample_stb stays 0, and counting resumes 1, 2, ...
- reset_fsm coincident with c2_rise at slot_cnt = 5 -> slot_cnt = 0, not 6.
- With YM3438_SLOT_PERIOD_CHECK_EN:
  - stretch one c2 interval to 7 MCLK -> period_err rises at that c2_rise and stays high through further good periods;
  - IC low clears it.

Source files
------------

// File: rtl/ym3438_timing_pkg.sv
// Shared timebase constants and slot/channel/operator index types for the YM3438 core.
package ym3438_timing_pkg;

  localparam int YM_SLOTS    = 24;
  localparam int YM_OPS      = 4;
  localparam int YM_CHANNELS = 6;
  localparam int YM_PRESCALE = 6;

  localparam int YM_SLOT_W = $clog2(YM_SLOTS);
  localparam int YM_CH_W   = $clog2(YM_CHANNELS);
  localparam int YM_OP_W   = $clog2(YM_OPS);

  typedef logic [YM_SLOT_W-1:0] slot_t;
  typedef logic [YM_CH_W-1:0]   ch_t;
  typedef logic [YM_OP_W-1:0]   op_t;

endpackage

// File: rtl/ym3438_edge_det.sv
// Registers a prescaler phase level in the MCLK domain and flags its rising edge.
module ym3438_edge_det (
  input  logic MCLK,
  input  logic IC,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge MCLK) begin
    if (!IC) d_q <= 1'b0;
    else     d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/ym3438_slot_timer.sv
// 24-slot operator/channel timebase driven by the prescaler's c1/c2 phases.
// Define YM3438_SLOT_PERIOD_CHECK_EN to add the c2 period watchdog and period_err port.
module ym3438_slot_timer
  import ym3438_timing_pkg::*;
#(
  parameter int SLOTS  = YM_SLOTS,
  parameter int OPS    = YM_OPS,
`ifdef YM3438_SLOT_PERIOD_CHECK_EN
  parameter int PERIOD = YM_PRESCALE,
`endif
  parameter int SLOT_W = $clog2(SLOTS),
  parameter int CH_W   = $clog2(SLOTS / OPS),
  parameter int OP_W   = $clog2(OPS)
) (
  input  logic              MCLK,
  input  logic              IC,
  input  logic              c1,
  input  logic              c2,
  input  logic              reset_fsm,
  output logic [SLOT_W-1:0] slot,
  output logic [CH_W-1:0]   ch,
  output logic [OP_W-1:0]   op,
  output logic              slot_first,
  output logic              slot_last,
  output logic              sample_stb,
  output logic              synced
`ifdef YM3438_SLOT_PERIOD_CHECK_EN
  ,
  output logic              period_err
`endif
);

  localparam int CHANS = SLOTS / OPS;

  logic [SLOT_W-1:0] slot_cnt;
  logic              c1_rise;
  logic              c2_rise;
  logic              cnt_wrap;
  // Set while slot_cnt holds a 0 forced by reset_fsm rather than reached by wrapping.
  logic              cnt_forced;

  ym3438_edge_det u_c1_det (.MCLK(MCLK), .IC(IC), .d(c1), .rise(c1_rise));
  ym3438_edge_det u_c2_det (.MCLK(MCLK), .IC(IC), .d(c2), .rise(c2_rise));

  assign cnt_wrap = (slot_cnt == SLOT_W'(SLOTS - 1));

  always_ff @(posedge MCLK) begin
    if (!IC) begin
      slot_cnt   <= '0;
      cnt_forced <= 1'b0;
      synced     <= 1'b0;
      slot       <= '0;
      ch         <= '0;
      op         <= '0;
      slot_first <= 1'b0;
      slot_last  <= 1'b0;
      sample_stb <= 1'b0;
    end else begin
      if (reset_fsm) begin
        slot_cnt   <= '0;
        cnt_forced <= 1'b1;
        synced     <= 1'b1;
      end else if (c2_rise) begin
        slot_cnt   <= cnt_wrap ? '0 : slot_cnt + 1'b1;
        cnt_forced <= 1'b0;
      end

      sample_stb <= c1_rise && synced && !cnt_forced && (slot_cnt == '0) &&
                    (slot == SLOT_W'(SLOTS - 1));

      if (c1_rise) begin
        slot       <= slot_cnt;
        ch         <= CH_W'(slot_cnt % SLOT_W'(CHANS));
        op         <= OP_W'(slot_cnt / SLOT_W'(CHANS));
        slot_first <= (slot_cnt == '0);
        slot_last  <= cnt_wrap;
      end
    end
  end

`ifdef YM3438_SLOT_PERIOD_CHECK_EN
  logic [3:0] per_cnt;
  logic       per_seen;

  always_ff @(posedge MCLK) begin
    if (!IC) begin
      per_cnt    <= '0;
      per_seen   <= 1'b0;
      period_err <= 1'b0;
    end else if (reset_fsm) begin
      per_cnt  <= '0;
      per_seen <= 1'b0;
    end else if (c2_rise) begin
      if (synced && per_seen && (per_cnt != 4'(PERIOD))) period_err <= 1'b1;
      per_cnt  <= 4'd1;
      per_seen <= 1'b1;
    end else if (per_cnt != 4'hF) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ym3438_slot_timer.sv
// Directed bench for ym3438_slot_timer; covers YM3438_SLOT_PERIOD_CHECK_EN when defined.
module tb_ym3438_slot_timer;
  import ym3438_timing_pkg::*;

  logic  MCLK = 1'b0;
  logic  IC = 1'b0;
  logic  c1 = 1'b0;
  logic  c2 = 1'b0;
  logic  reset_fsm = 1'b0;
  slot_t slot;
  ch_t   ch;
  op_t   op;
  logic  slot_first;
  logic  slot_last;
  logic  sample_stb;
  logic  synced;
`ifdef YM3438_SLOT_PERIOD_CHECK_EN
  logic  period_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  ym3438_slot_timer dut (
    .MCLK(MCLK),
    .IC(IC),
    .c1(c1),
    .c2(c2),
    .reset_fsm(reset_fsm),
    .slot(slot),
    .ch(ch),
    .op(op),
    .slot_first(slot_first),
    .slot_last(slot_last),
    .sample_stb(sample_stb),
    .synced(synced)
`ifdef YM3438_SLOT_PERIOD_CHECK_EN
    ,
    .period_err(period_err)
`endif
  );

  always #5 MCLK = ~MCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCLK);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input logic r);
    c1 = a;
    c2 = b;
    reset_fsm = r;
    tick();
    reset_fsm = 1'b0;
  endtask

  // Prescaler pattern: c1 high at phases 5,0; c2 high at phases 2,3.
  task automatic phase(input int p, input logic r = 1'b0);
    drive((p == 0) || (p == 5), (p == 2) || (p == 3), r);
  endtask

  task automatic run_period(input int exp_slot, input bit exp_stb);
    for (int p = 1; p <= 6; p++) begin
      phase(p % 6);
      chk("stb", sample_stb, (p == 5) && exp_stb);
      if (p == 5) begin
        chk("slot", slot, exp_slot);
        chk("first", slot_first, exp_slot == 0);
        chk("last", slot_last, exp_slot == 23);
      end
    end
  endtask

  initial begin
    // Reset with phases toggling
    for (int i = 0; i < 3; i++) drive(i % 2 == 1, i % 2 == 0, 1'b0);
    chk("rst_slot", slot, 0);
    chk("rst_ch", ch, 0);
    chk("rst_op", op, 0);
    chk("rst_first", slot_first, 0);
    chk("rst_last", slot_last, 0);
    chk("rst_stb", sample_stb, 0);
    chk("rst_synced", synced, 0);
`ifdef YM3438_SLOT_PERIOD_CHECK_EN
    chk("rst_perr", period_err, 0);
`endif

    // Free-running before sync; outputs hold until first c1 rise
    IC = 1'b1;
    phase(1); chk("hold1", slot, 0);
    phase(2); chk("hold2", slot, 0);
    phase(3);
    phase(4); chk("hold4", slot, 0);
    chk("unsynced", synced, 0);
    phase(5); chk("free_slot", slot, 1);
    phase(0);

    // Resync pulse at phase 3 (after the c2 rise)
    phase(1);
    phase(2);
    phase(3, 1'b1); chk("synced", synced, 1);
    phase(4);
    phase(5);
    chk("sync_slot", slot, 0);
    chk("sync_stb", sample_stb, 0);
    chk("sync_first", slot_first, 1);
    phase(0);

    // Full frame 1..23 then wrap to 0 with one-cycle strobe
    for (int k = 1; k <= 24; k++) begin
      run_period(k % 24, k == 24);
      if (k == 7) begin
        chk("ch7", ch, 1);
        chk("op7", op, 1);
      end
      if (k == 23) begin
        chk("ch23", ch, 5);
        chk("op23", op, 3);
      end
    end

    // reset_fsm mid-frame at slot_cnt 13
    for (int k = 1; k <= 12; k++) run_period(k, 1'b0);
    phase(1);
    phase(2);
    phase(3, 1'b1);
    phase(4);
    phase(5);
    chk("mid_slot", slot, 0);
    chk("mid_stb", sample_stb, 0);
    phase(0);
    chk("mid_stb2", sample_stb, 0);
    run_period(1, 1'b0);
    run_period(2, 1'b0);

    // reset_fsm coincident with c2 rise at slot_cnt 5
    for (int k = 3; k <= 5; k++) run_period(k, 1'b0);
    phase(1);
    phase(2, 1'b1);
    phase(3);
    phase(4);
    phase(5);
    chk("coinc_rst_slot", slot, 0);
    phase(0);
    run_period(1, 1'b0);

    // Coincident c1/c2 rises: latch takes the pre-increment count
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    chk("coinc_pre", slot, 1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    chk("coinc_post", slot, 2);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    run_period(3, 1'b0);

`ifdef YM3438_SLOT_PERIOD_CHECK_EN
    chk("perr_clean", period_err, 0);
    phase(1);
    phase(1);
    chk("perr_before", period_err, 0);
    phase(2);
    chk("perr_set", period_err, 1);
    phase(3);
    phase(4);
    phase(5);
    chk("stretch_slot", slot, 4);
    phase(0);
    run_period(5, 1'b0);
    run_period(6, 1'b0);
    chk("perr_sticky", period_err, 1);
`else
    run_period(4, 1'b0);
    run_period(5, 1'b0);
`endif

    IC = 1'b0;
    tick();
    chk("ic_slot", slot, 0);
    chk("ic_synced", synced, 0);
`ifdef YM3438_SLOT_PERIOD_CHECK_EN
    chk("ic_perr", period_err, 0);
`endif
    IC = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
